// File: rtl/dtm_timing_tx_framer.sv
// Timing word framer for one COB timing TX lane: merges trigger, periodic sync and
// queued software command words into a registered 10-bit stream under txReady back-pressure.
module dtm_timing_tx_framer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_PERIOD = 256,
    parameter logic [9:0]  TRIG_WORD   = 10'h2A5,
    parameter logic [9:0]  SYNC_WORD   = 10'h3FC,
    parameter logic [9:0]  IDLE_WORD   = 10'h000
) (
    input  logic        distClk,
    input  logic        distClkRstL,
    input  logic        trigReq,
    input  logic        cmdValid,
    input  logic [7:0]  cmdData,
    output logic        cmdReady,
    input  logic        txReady,
    output logic [9:0]  txData,
    output logic        txDataEn,
    output logic [15:0] trigDropCnt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [CW-1:0] PERIOD_LAST = CW'(SYNC_PERIOD - 1);
    localparam logic [AW:0]   FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_TRIG,
        SEL_SYNC,
        SEL_CMD
    } sel_t;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   fifoCount;
    logic [AW:0]   fifoCountNext;
    logic [CW-1:0] periodCnt;
    logic          periodWrap;
    logic          trigPend;
    logic          syncPend;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    sel_t          sel;
    logic [9:0]    selWord;

    assign fifoEmpty  = (fifoCount == '0);
    assign push       = cmdValid && cmdReady;
    assign pop        = txReady && (sel == SEL_CMD);
    assign periodWrap = (periodCnt == PERIOD_LAST);

    always_comb begin
        sel     = SEL_IDLE;
        selWord = IDLE_WORD;
        if (trigReq || trigPend) begin
            sel     = SEL_TRIG;
            selWord = TRIG_WORD;
        end else if (syncPend) begin
            sel     = SEL_SYNC;
            selWord = SYNC_WORD;
        end else if (!fifoEmpty) begin
            sel     = SEL_CMD;
            selWord = {2'b01, fifoMem[rdPtr]};
        end
    end

    always_comb begin
        fifoCountNext = fifoCount;
        if (push && !pop) begin
            fifoCountNext = fifoCount + 1'b1;
        end else if (pop && !push) begin
            fifoCountNext = fifoCount - 1'b1;
        end
    end

    always_ff @(posedge distClk) begin
        if (push) begin
            fifoMem[wrPtr] <= cmdData;
        end
    end

    always_ff @(posedge distClk or negedge distClkRstL) begin
        if (!distClkRstL) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            cmdReady  <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            fifoCount <= fifoCountNext;
            cmdReady  <= (fifoCountNext != FIFO_FULL);
        end
    end

    // A trigger arriving while a pending one is sent takes its place; while stalled it is dropped.
    always_ff @(posedge distClk or negedge distClkRstL) begin
        if (!distClkRstL) begin
            periodCnt   <= '0;
            trigPend    <= 1'b0;
            syncPend    <= 1'b0;
            trigDropCnt <= '0;
        end else begin
            periodCnt <= periodWrap ? '0 : periodCnt + 1'b1;
            trigPend  <= txReady ? (trigPend && trigReq) : (trigPend || trigReq);
            syncPend  <= (syncPend && !(txReady && (sel == SEL_SYNC))) || periodWrap;
            if (!txReady && trigPend && trigReq && (trigDropCnt != '1)) begin
                trigDropCnt <= trigDropCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge distClk or negedge distClkRstL) begin
        if (!distClkRstL) begin
            txData   <= IDLE_WORD;
            txDataEn <= 1'b0;
        end else begin
            txDataEn <= txReady;
            if (txReady) begin
                txData <= selWord;
            end
        end
    end
endmodule

// File: tb/tb_dtm_timing_tx_framer.sv
// Vector/scoreboard bench for dtm_timing_tx_framer; dutA uses the default sync period,
// dutB a short one so the sync/trigger/command priority can be exercised.
module tb_dtm_timing_tx_framer;
    logic        distClk = 1'b0;
    logic        distClkRstL = 1'b1;
    logic        trigReq = 1'b0;
    logic        cmdValid = 1'b0;
    logic [7:0]  cmdData = '0;
    logic        txReady = 1'b0;

    logic        cmdReadyA, cmdReadyB;
    logic [9:0]  txDataA, txDataB;
    logic        txDataEnA, txDataEnB;
    logic [15:0] trigDropCntA, trigDropCntB;

    logic        useB = 1'b0;
    logic [9:0]  obsData;
    logic        obsEn;
    logic        obsReady;
    logic [15:0] obsDrop;

    int unsigned nChecks = 0;
    int unsigned nFail = 0;

    typedef struct {
        logic        trig;
        logic        cv;
        logic [7:0]  cd;
        logic        rdy;
        logic [9:0]  expData;
        logic        expEn;
        logic        expCmdRdy;
        logic [15:0] expDrop;
    } vec_t;

    typedef struct {
        logic [9:0]  data;
        logic        en;
        logic        cmdRdy;
        logic [15:0] drop;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];

    dtm_timing_tx_framer #(.FIFO_DEPTH(4), .SYNC_PERIOD(256)) dutA (
        .distClk(distClk), .distClkRstL(distClkRstL), .trigReq(trigReq),
        .cmdValid(cmdValid), .cmdData(cmdData), .cmdReady(cmdReadyA),
        .txReady(txReady), .txData(txDataA), .txDataEn(txDataEnA),
        .trigDropCnt(trigDropCntA)
    );

    dtm_timing_tx_framer #(.FIFO_DEPTH(4), .SYNC_PERIOD(16)) dutB (
        .distClk(distClk), .distClkRstL(distClkRstL), .trigReq(trigReq),
        .cmdValid(cmdValid), .cmdData(cmdData), .cmdReady(cmdReadyB),
        .txReady(txReady), .txData(txDataB), .txDataEn(txDataEnB),
        .trigDropCnt(trigDropCntB)
    );

    assign obsData  = useB ? txDataB      : txDataA;
    assign obsEn    = useB ? txDataEnB    : txDataEnA;
    assign obsReady = useB ? cmdReadyB    : cmdReadyA;
    assign obsDrop  = useB ? trigDropCntB : trigDropCntA;

    always #5 distClk = ~distClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic t, input logic cv, input logic [7:0] cd,
                                   input logic r, input logic [9:0] d, input logic en,
                                   input logic cr, input logic [15:0] dr);
        vec_t v;
        v.trig = t; v.cv = cv; v.cd = cd; v.rdy = r;
        v.expData = d; v.expEn = en; v.expCmdRdy = cr; v.expDrop = dr;
        vecs.push_back(v);
    endfunction

    task automatic runVecs(input string tag);
        exp_t e;
        foreach (vecs[i]) begin
            trigReq  = vecs[i].trig;
            cmdValid = vecs[i].cv;
            cmdData  = vecs[i].cd;
            txReady  = vecs[i].rdy;
            e.data = vecs[i].expData; e.en = vecs[i].expEn;
            e.cmdRdy = vecs[i].expCmdRdy; e.drop = vecs[i].expDrop;
            expQ.push_back(e);
            @(posedge distClk);
            #1;
            e = expQ.pop_front();
            check($sformatf("%s[%0d].txData", tag, i), 32'(obsData), 32'(e.data));
            check($sformatf("%s[%0d].txDataEn", tag, i), 32'(obsEn), 32'(e.en));
            check($sformatf("%s[%0d].cmdReady", tag, i), 32'(obsReady), 32'(e.cmdRdy));
            check($sformatf("%s[%0d].trigDropCnt", tag, i), 32'(obsDrop), 32'(e.drop));
        end
        trigReq  = 1'b0;
        cmdValid = 1'b0;
        vecs.delete();
    endtask

    // Asserts reset mid-cycle (async clear checked immediately), releases it mid-cycle.
    task automatic doReset(input string tag, input logic rdy);
        trigReq = 1'b0; cmdValid = 1'b0; cmdData = '0; txReady = rdy;
        distClkRstL = 1'b0;
        #1;
        check({tag, ".rst.txData"}, 32'(obsData), 32'h000);
        check({tag, ".rst.txDataEn"}, 32'(obsEn), 32'h0);
        check({tag, ".rst.cmdReady"}, 32'(obsReady), 32'h0);
        check({tag, ".rst.trigDropCnt"}, 32'(obsDrop), 32'h0);
        @(posedge distClk);
        @(posedge distClk);
        #1;
        distClkRstL = 1'b1;
        check({tag, ".release.txDataEn"}, 32'(obsEn), 32'h0);
        check({tag, ".release.cmdReady"}, 32'(obsReady), 32'h0);
        @(posedge distClk);
        #1;
        check({tag, ".first.txData"}, 32'(obsData), 32'h000);
        check({tag, ".first.txDataEn"}, 32'(obsEn), 32'(rdy));
        check({tag, ".first.cmdReady"}, 32'(obsReady), 32'h1);
    endtask

    initial begin
        @(posedge distClk);
        #1;

        // T1/T2: reset with txReady high, then trigger latency.
        useB = 1'b0;
        doReset("T1", 1'b1);
        for (int i = 0; i < 13; i++) begin
            addVec(i == 10, 1'b0, 8'h00, 1'b1, (i == 10) ? 10'h2A5 : 10'h000, 1'b1, 1'b1, 16'd0);
        end
        runVecs("T2");

        // T3: fill FIFO while stalled, push-when-full ignored, push+pop, empty push gives idle.
        doReset("T3", 1'b0);
        addVec(1'b0, 1'b1, 8'h11, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h22, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h33, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h44, 1'b0, 10'h000, 1'b0, 1'b0, 16'd0);
        addVec(1'b0, 1'b1, 8'h55, 1'b1, 10'h111, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h66, 1'b1, 10'h122, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h133, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h144, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h166, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h77, 1'b1, 10'h000, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h177, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h000, 1'b1, 1'b1, 16'd0);
        runVecs("T3");

        // T4: second trigger while stalled is dropped; only one trigger word follows.
        doReset("T4", 1'b0);
        for (int i = 0; i < 10; i++) begin
            addVec((i == 5) || (i == 8), 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1,
                   (i >= 8) ? 16'd1 : 16'd0);
        end
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h2A5, 1'b1, 1'b1, 16'd1);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h000, 1'b1, 1'b1, 16'd1);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h000, 1'b1, 1'b1, 16'd1);
        runVecs("T4");

        // T5: on the short-period instance, trigger arrives the first cycle sync is pending.
        useB = 1'b1;
        doReset("T5", 1'b0);
        addVec(1'b0, 1'b1, 8'hAA, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'hBB, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'hCC, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        for (int i = 3; i < 15; i++) begin
            addVec(1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        end
        addVec(1'b1, 1'b0, 8'h00, 1'b1, 10'h2A5, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h3FC, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h1AA, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h1BB, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h1CC, 1'b1, 1'b1, 16'd0);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h000, 1'b1, 1'b1, 16'd0);
        runVecs("T5");

        // T6: queue commands, cause a drop, emit a trigger, then reset mid-stream.
        useB = 1'b0;
        doReset("T6a", 1'b0);
        addVec(1'b0, 1'b1, 8'h01, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h02, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b0, 1'b1, 8'h03, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, 1'b1, 16'd1);
        addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h2A5, 1'b1, 1'b1, 16'd1);
        runVecs("T6pre");
        doReset("T6b", 1'b1);
        for (int i = 0; i < 6; i++) begin
            addVec(1'b0, 1'b0, 8'h00, 1'b1, 10'h000, 1'b1, 1'b1, 16'd0);
        end
        runVecs("T6post");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
